eq_band_programmer: RTL and testbench

EQ_BAND_PROGRAMMER -- requirements
Module: eq_band_programmer

---
 rtl/eq_band_programmer_if.sv | 27 ++
 rtl/eq_band_programmer.sv | 165 ++++++++++++++++
 tb/tb_eq_band_programmer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_band_programmer_if.sv
// rtl/eq_band_programmer_if.sv - equalizer register bus between band programmer and equalizer
interface eq_band_programmer_if;
    logic [3:0] address;
    logic [7:0] writedata;
    logic       chipselect;
    logic       write;
    logic       read;
    logic [7:0] readdata;

    modport master (
        output address,
        output writedata,
        output chipselect,
        output write,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  writedata,
        input  chipselect,
        input  write,
        input  read,
        output readdata
    );
endinterface

// File: rtl/eq_band_programmer.sv
// rtl/eq_band_programmer.sv - shadows band gains and pushes them to the equalizer bus with optional read-back verify
module eq_band_programmer #(
    parameter int         NBANDS       = 12,
    parameter logic [4:0] DEFAULT_GAIN = 5'd13,
    parameter bit         VERIFY       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_band_we,
    input  logic [3:0]            i_band_idx,
    input  logic [4:0]            i_band_val,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [3:0]            o_err_idx,
    eq_band_programmer_if.master  bus
);

    localparam logic [4:0] LP_NBANDS = 5'(NBANDS);
    localparam logic [3:0] LP_LAST   = 4'(NBANDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CMP,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_shadow [0:NBANDS-1];
    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;
    logic       r_retry;
    logic       w_retry_nxt;
    logic       r_error;
    logic       w_error_nxt;
    logic [3:0] r_err_idx;
    logic [3:0] w_err_idx_nxt;
    logic       w_advance;
    logic       w_pass;
    logic       w_idx_ok;
    logic [4:0] w_gain_nxt;

    assign w_idx_ok   = ({1'b0, i_band_idx} < LP_NBANDS);
    assign w_pass     = (bus.readdata == {3'b000, r_shadow[r_idx]});
    assign w_gain_nxt = r_shadow[w_idx_nxt];

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_error   = r_error;
    assign o_err_idx = r_err_idx;

    // Shadow gain table: host loads only while idle so a push always sees a stable snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBANDS; i++) begin
                r_shadow[i] <= DEFAULT_GAIN;
            end
        end else if (r_state == S_IDLE && i_band_we && w_idx_ok) begin
            r_shadow[i_band_idx] <= i_band_val;
        end
    end

    // State, band counter, retry and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 4'd0;
            r_retry   <= 1'b0;
            r_error   <= 1'b0;
            r_err_idx <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_retry   <= w_retry_nxt;
            r_error   <= w_error_nxt;
            r_err_idx <= w_err_idx_nxt;
        end
    end

    // Next-state logic: write each band, optionally read back, one retry before flagging an error
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_retry_nxt   = r_retry;
        w_error_nxt   = r_error;
        w_err_idx_nxt = r_err_idx;
        w_advance     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = S_WRITE;
                    w_idx_nxt     = 4'd0;
                    w_retry_nxt   = 1'b0;
                    w_error_nxt   = 1'b0;
                    w_err_idx_nxt = 4'd0;
                end
            end
            S_WRITE: begin
                if (VERIFY) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_READ: begin
                w_state_nxt = S_CMP;
            end
            S_CMP: begin
                if (w_pass) begin
                    w_advance = 1'b1;
                end else if (!r_retry) begin
                    w_retry_nxt = 1'b1;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_error_nxt = 1'b1;
                    if (!r_error) begin
                        w_err_idx_nxt = r_idx;
                    end
                    w_advance = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_advance) begin
            w_retry_nxt = 1'b0;
            if (r_idx == LP_LAST) begin
                w_state_nxt = S_DONE;
            end else begin
                w_idx_nxt   = r_idx + 4'd1;
                w_state_nxt = S_WRITE;
            end
        end
    end

    // Bus strobes and payload registered from the next state so they line up with WRITE/READ cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.chipselect <= 1'b0;
            bus.write      <= 1'b0;
            bus.read       <= 1'b0;
            bus.address    <= 4'd0;
            bus.writedata  <= 8'd0;
        end else begin
            bus.chipselect <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ);
            bus.write      <= (w_state_nxt == S_WRITE);
            bus.read       <= (w_state_nxt == S_READ);
            if (w_state_nxt == S_WRITE || w_state_nxt == S_READ) begin
                bus.address <= w_idx_nxt;
            end
            if (w_state_nxt == S_WRITE) begin
                bus.writedata <= {3'b000, w_gain_nxt};
            end
        end
    end

endmodule

// File: tb/tb_eq_band_programmer.sv
// tb/tb_eq_band_programmer.sv - scoreboard bench for eq_band_programmer
module tb_eq_band_programmer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       band_we = 1'b0;
    logic [3:0] band_idx = 4'd0;
    logic [4:0] band_val = 5'd0;
    logic       start_v = 1'b0;
    logic       start_nv = 1'b0;

    logic       busy_v, done_v, error_v;
    logic [3:0] err_idx_v;
    logic       busy_nv, done_nv, error_nv;
    logic [3:0] err_idx_nv;

    eq_band_programmer_if bus_v ();
    eq_band_programmer_if bus_nv ();

    eq_band_programmer #(.NBANDS(12), .DEFAULT_GAIN(5'd13), .VERIFY(1'b1)) dut (
        .clk(clk), .reset(reset), .i_band_we(band_we), .i_band_idx(band_idx),
        .i_band_val(band_val), .i_start(start_v), .o_busy(busy_v), .o_done(done_v),
        .o_error(error_v), .o_err_idx(err_idx_v), .bus(bus_v)
    );

    eq_band_programmer #(.NBANDS(12), .DEFAULT_GAIN(5'd13), .VERIFY(1'b0)) dut_nv (
        .clk(clk), .reset(reset), .i_band_we(band_we), .i_band_idx(band_idx),
        .i_band_val(band_val), .i_start(start_nv), .o_busy(busy_nv), .o_done(done_nv),
        .o_error(error_nv), .o_err_idx(err_idx_nv), .bus(bus_nv)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem_v [0:15];
    logic [15:0] stuck = 16'h0;
    int          once_band = -1;
    int          once_token = 0;
    int          once_used = 0;

    always @(posedge clk) begin
        if (bus_v.chipselect && bus_v.write) mem_v[bus_v.address] <= bus_v.writedata;
        if (bus_v.chipselect && bus_v.read) begin
            if (stuck[bus_v.address]) begin
                bus_v.readdata <= mem_v[bus_v.address] ^ 8'h5A;
            end else if (int'(bus_v.address) == once_band && once_used != once_token) begin
                bus_v.readdata <= mem_v[bus_v.address] ^ 8'h5A;
                once_used <= once_token;
            end else begin
                bus_v.readdata <= mem_v[bus_v.address];
            end
        end
    end

    assign bus_nv.readdata = 8'h00;

    bit         sel = 1'b0;
    logic       m_cs, m_wr, m_rd, m_done;
    logic [3:0] m_addr;
    logic [7:0] m_wd;
    assign m_cs   = sel ? bus_nv.chipselect : bus_v.chipselect;
    assign m_wr   = sel ? bus_nv.write      : bus_v.write;
    assign m_rd   = sel ? bus_nv.read       : bus_v.read;
    assign m_addr = sel ? bus_nv.address    : bus_v.address;
    assign m_wd   = sel ? bus_nv.writedata  : bus_v.writedata;
    assign m_done = sel ? done_nv           : done_v;

    logic [4:0]  m_shadow [0:11];
    logic [11:0] exp_q [$];
    logic [11:0] obs_q [$];
    int          wcyc_q [$];
    int          done_cyc;
    bit          saw_read, saw_both;

    function automatic void model_reset();
        for (int i = 0; i < 12; i++) m_shadow[i] = 5'd13;
    endfunction

    function automatic int build_exp(input int ob, input logic [15:0] sk);
        int retries = 0;
        exp_q.delete();
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back({4'(k), 3'b000, m_shadow[k]});
            if (k == ob || sk[k]) begin
                exp_q.push_back({4'(k), 3'b000, m_shadow[k]});
                retries++;
            end
        end
        return 37 + 3 * retries;
    endfunction

    task automatic set_band(input logic [3:0] idx, input logic [4:0] val);
        @(posedge clk); #1;
        band_we = 1'b1; band_idx = idx; band_val = val;
        @(posedge clk); #1;
        band_we = 1'b0;
        if (idx < 4'd12) m_shadow[idx] = val;
    endtask

    task automatic collect(input bit s, input int budget);
        obs_q.delete(); wcyc_q.delete();
        done_cyc = -1; saw_read = 1'b0; saw_both = 1'b0;
        sel = s;
        @(posedge clk); #1;
        if (s) start_nv = 1'b1; else start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0; start_nv = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (m_cs && m_wr) begin
                obs_q.push_back({m_addr, m_wd});
                wcyc_q.push_back(c);
            end
            if (m_rd) saw_read = 1'b1;
            if (m_wr && m_rd) saw_both = 1'b1;
            if (m_done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1; start_v = 1'b1; band_we = 1'b1; band_idx = 4'd0; band_val = 5'd31;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; start_v = 1'b0; band_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy_v, done_v, error_v, err_idx_v} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_status got busy=%b done=%b err=%b err_idx=%0d want all 0", busy_v, done_v, error_v, err_idx_v);
        end
        n_vec++;
        if ({bus_v.chipselect, bus_v.write, bus_v.read, bus_v.address, bus_v.writedata} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_bus got cs=%b wr=%b rd=%b addr=%0d wd=%h want all 0", bus_v.chipselect, bus_v.write, bus_v.read, bus_v.address, bus_v.writedata);
        end
    endtask

    task automatic test_push(input string name, input int ob, input logic [15:0] sk,
                             input logic exp_err, input logic [3:0] exp_eidx);
        int exp_done;
        logic [11:0] e, o;
        stuck = sk;
        once_band = ob;
        once_token++;
        exp_done = build_exp(ob, sk);
        collect(1'b0, 80);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s write_count got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s write got addr=%0d data=%h want addr=%0d data=%h", name, o[11:8], o[7:0], e[11:8], e[7:0]);
            end
        end
        n_vec++;
        if (done_cyc != exp_done) begin
            n_err++;
            $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, exp_done);
        end
        n_vec++;
        if (error_v !== exp_err || (exp_err && err_idx_v !== exp_eidx)) begin
            n_err++;
            $display("FAIL %s error got err=%b idx=%0d want err=%b idx=%0d", name, error_v, err_idx_v, exp_err, exp_eidx);
        end
        n_vec++;
        if (saw_both) begin
            n_err++;
            $display("FAIL %s strobe_overlap got write&read=1 want 0", name);
        end
        stuck = 16'h0;
        once_band = -1;
        @(negedge clk);
        n_vec++;
        if (busy_v !== 1'b0 || done_v !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done got busy=%b done=%b want 0 0", name, busy_v, done_v);
        end
    endtask

    task automatic test_load_bands();
        set_band(4'd4, 5'd31);
        set_band(4'd11, 5'd0);
        set_band(4'd12, 5'd3);
        test_push("loaded", -1, 16'h0, 1'b0, 4'd0);
    endtask

    task automatic test_sticky_error();
        test_push("stuck", -1, 16'h0204, 1'b1, 4'd2);
        n_vec++;
        if (error_v !== 1'b1 || err_idx_v !== 4'd2) begin
            n_err++;
            $display("FAIL sticky_hold got err=%b idx=%0d want 1 2", error_v, err_idx_v);
        end
        test_push("clear", -1, 16'h0, 1'b0, 4'd0);
    endtask

    task automatic test_busy_reset();
        obs_q.delete(); wcyc_q.delete(); exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back({4'(k), 3'b000, m_shadow[k]});
        sel = 1'b0;
        @(posedge clk); #1; start_v = 1'b1;
        @(posedge clk); #1; start_v = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (m_cs && m_wr) obs_q.push_back({m_addr, m_wd});
            if (c == 2) begin band_we = 1'b1; band_idx = 4'd3; band_val = 5'd5; end
            if (c == 3) band_we = 1'b0;
            if (c == 5) start_v = 1'b1;
            if (c == 6) start_v = 1'b0;
            if (c == 10) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_vec++;
        if (obs_q.size() != 4) begin
            n_err++;
            $display("FAIL busy_writes count got %0d want 4", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            logic [11:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL busy_write got addr=%0d data=%h want addr=%0d data=%h", o[11:8], o[7:0], e[11:8], e[7:0]);
            end
        end
        n_vec++;
        if ({bus_v.chipselect, bus_v.write, bus_v.read, busy_v} !== 4'b0) begin
            n_err++;
            $display("FAIL abort_strobes got cs=%b wr=%b rd=%b busy=%b want 0", bus_v.chipselect, bus_v.write, bus_v.read, busy_v);
        end
        saw_read = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_v || bus_v.chipselect) saw_read = 1'b1;
        end
        n_vec++;
        if (saw_read) begin
            n_err++;
            $display("FAIL abort_quiet got activity=1 want 0");
        end
        test_push("post_reset", -1, 16'h0, 1'b0, 4'd0);
    endtask

    task automatic test_no_verify();
        void'(build_exp(-1, 16'h0));
        collect(1'b1, 40);
        n_vec++;
        if (obs_q.size() != 12) begin
            n_err++;
            $display("FAIL nv_count got %0d want 12", obs_q.size());
        end
        for (int k = 0; k < 12; k++) begin
            logic [11:0] e, o;
            int cy;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            cy = (wcyc_q.size() > 0) ? wcyc_q.pop_front() : -1;
            n_vec++;
            if (o !== e || cy != k + 1) begin
                n_err++;
                $display("FAIL nv_write got addr=%0d data=%h cycle=%0d want addr=%0d data=%h cycle=%0d", o[11:8], o[7:0], cy, e[11:8], e[7:0], k + 1);
            end
        end
        n_vec++;
        if (done_cyc != 13) begin
            n_err++;
            $display("FAIL nv_done got %0d want 13", done_cyc);
        end
        n_vec++;
        if (saw_read) begin
            n_err++;
            $display("FAIL nv_read got read=1 want 0");
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push("default", -1, 16'h0, 1'b0, 4'd0);
        test_load_bands();
        test_push("retry_once", 7, 16'h0, 1'b0, 4'd0);
        test_sticky_error();
        test_busy_reset();
        test_no_verify();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
